lcd_frame_writer: RTL



---
 rtl/cpu_pkg.sv | 81 ++++++++
 rtl/lcd_frame_writer_if.sv | 20 ++
 rtl/lcd_frame_writer_bin2bcd.sv | 66 ++++++
 rtl/lcd_frame_writer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encoding, HD44780 command bytes, ASCII codes
// and the small character helpers used by the LCD frame writer.
package cpu_pkg;

    typedef enum logic [2:0] {
        OP_LOAD    = 3'd0,
        OP_ADD     = 3'd1,
        OP_ADDI    = 3'd2,
        OP_SUB     = 3'd3,
        OP_SUBI    = 3'd4,
        OP_MUL     = 3'd5,
        OP_CLEAR   = 3'd6,
        OP_DISPLAY = 3'd7
    } opcode_e;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_LINE1    = 8'h80;
    localparam logic [7:0] LCD_LINE2    = 8'hC0;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_R     = 8'h52;

    typedef enum logic [2:0] {
        ST_POWERON,
        ST_INIT,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD
    } lcd_state_e;

    typedef struct packed {
        opcode_e    opcode;
        logic [3:0] dest;
        logic [3:0] src1;
        logic [3:0] src2;
        logic       neg;
    } frame_fields_t;

    function automatic logic [7:0] hex_ascii(input logic [3:0] v);
        return (v < 4'd10) ? (ASCII_ZERO + {4'd0, v}) : (ASCII_A + {4'd0, v} - 8'd10);
    endfunction

    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd3:    return LCD_DISP_ON;
            3'd4:    return LCD_CLEAR;
            3'd5:    return LCD_ENTRY;
            default: return LCD_FUNC_SET;
        endcase
    endfunction

    function automatic logic [7:0] mnemonic_char(input opcode_e op, input logic [1:0] col);
        logic [31:0] s;
        s = "LOAD";
        case (op)
            OP_LOAD:    s = "LOAD";
            OP_ADD:     s = "ADD ";
            OP_ADDI:    s = "ADDI";
            OP_SUB:     s = "SUB ";
            OP_SUBI:    s = "SUBI";
            OP_MUL:     s = "MUL ";
            OP_CLEAR:   s = "CLR ";
            OP_DISPLAY: s = "DISP";
        endcase
        case (col)
            2'd0:    return s[31:24];
            2'd1:    return s[23:16];
            2'd2:    return s[15:8];
            default: return s[7:0];
        endcase
    endfunction

endpackage

// File: rtl/lcd_frame_writer_if.sv
// Frame-request handshake between the CPU core (master) and the LCD writer (slave).
interface lcd_frame_writer_if;
    logic              start;
    cpu_pkg::opcode_e  opcode;
    logic [3:0]        reg_dest;
    logic [3:0]        reg_src1;
    logic [3:0]        reg_src2;
    logic [15:0]       resultado;
    logic              ready;

    modport master (
        output start, opcode, reg_dest, reg_src1, reg_src2, resultado,
        input  ready
    );

    modport slave (
        input  start, opcode, reg_dest, reg_src1, reg_src2, resultado,
        output ready
    );
endinterface

// File: rtl/lcd_frame_writer_bin2bcd.sv
// Iterative double-dabble: 16-bit unsigned to five BCD digits, one bit per cycle.
// done rises 17 cycles after go and holds the digits until the next go.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic [15:0] bin,
    output logic        done,
    output logic [19:0] bcd
);
    logic [15:0] sh_q, sh_d;
    logic [19:0] bcd_q, bcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [19:0] adj;

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_dabble
            assign adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? (bcd_q[4*gi +: 4] + 4'd3)
                                                               : bcd_q[4*gi +: 4];
        end
    endgenerate

    always_comb begin
        sh_d   = sh_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = done_q;
        if (go) begin
            sh_d   = bin;
            bcd_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
            done_d = 1'b0;
        end else if (busy_q) begin
            bcd_d = {adj[18:0], sh_q[15]};
            sh_d  = {sh_q[14:0], 1'b0};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_q   <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign bcd  = bcd_q;
endmodule

// File: rtl/lcd_frame_writer.sv
// HD44780 8-bit writer: power-on init, then one 34-byte two-line frame per start.
// All LCD outputs are registered from the next-state values so they track the FSM exactly.
module lcd_frame_writer
    import cpu_pkg::*;
#(
    parameter int EN_PULSE_CYC   = 25,
    parameter int CMD_WAIT_CYC   = 2500,
    parameter int CLEAR_WAIT_CYC = 100000,
    parameter int POWERON_CYC    = 1000000
) (
    input  logic                clk,
    input  logic                reset,
    lcd_frame_writer_if.slave   req,
    output logic [7:0]          lcd_data,
    output logic                lcd_rs,
    output logic                lcd_rw,
    output logic                lcd_en
);
    localparam logic [31:0] POWERON_LAST = 32'(POWERON_CYC - 1);
    localparam logic [31:0] PULSE_LAST   = 32'(EN_PULSE_CYC - 1);
    localparam logic [31:0] CMD_LAST     = 32'(CMD_WAIT_CYC - 1);
    localparam logic [31:0] CLEAR_LAST   = 32'(CLEAR_WAIT_CYC - 1);

    lcd_state_e    state_q, state_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [5:0]    byte_q, byte_d;
    logic          init_q, init_d;
    frame_fields_t fields_q, fields_d;
    logic          ready_q, ready_d;
    logic          en_q, en_d;
    logic          rs_q, rs_d;
    logic [7:0]    data_q, data_d;

    logic          bcd_go, bcd_done;
    logic [19:0]   bcd_digits;
    logic [15:0]   magnitude;
    logic [31:0]   hold_last;
    logic          last_byte;
    logic [3:0]    col_l1, col_l2;
    logic [3:0]    digit;
    logic [7:0]    sel_data;
    logic          sel_rs;

    // Unsigned negate, so 16'h8000 converts to 32768.
    assign magnitude = req.resultado[15] ? (~req.resultado + 16'd1) : req.resultado;
    assign bcd_go    = (state_q == ST_IDLE) && req.start;

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .reset (reset),
        .go    (bcd_go),
        .bin   (magnitude),
        .done  (bcd_done),
        .bcd   (bcd_digits)
    );

    assign hold_last = (init_q && byte_q == 6'd4) ? CLEAR_LAST : CMD_LAST;
    assign last_byte = init_q ? (byte_q == 6'd5) : (byte_q == 6'd33);

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        byte_d   = byte_q;
        init_d   = init_q;
        fields_d = fields_q;
        case (state_q)
            ST_POWERON: begin
                if (cnt_q == POWERON_LAST) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_INIT: begin
                state_d = ST_SETUP;
                byte_d  = '0;
                init_d  = 1'b1;
            end
            ST_IDLE: begin
                if (req.start) begin
                    state_d         = ST_SETUP;
                    byte_d          = '0;
                    init_d          = 1'b0;
                    fields_d.opcode = req.opcode;
                    fields_d.dest   = req.reg_dest;
                    fields_d.src1   = req.reg_src1;
                    fields_d.src2   = req.reg_src2;
                    fields_d.neg    = req.resultado[15];
                end
            end
            ST_SETUP: begin
                state_d = ST_PULSE;
                cnt_d   = '0;
            end
            ST_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == hold_last) begin
                    cnt_d = '0;
                    if (last_byte) begin
                        state_d = ST_IDLE;
                        init_d  = 1'b0;
                    end else begin
                        state_d = ST_SETUP;
                        byte_d  = byte_q + 6'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = ST_POWERON;
        endcase
    end

    // Character selection for the byte about to be (or being) driven.
    assign col_l1 = 4'(byte_d - 6'd1);
    assign col_l2 = 4'(byte_d - 6'd18);

    always_comb begin
        digit = 4'd0;
        case (col_l2)
            4'd1: digit = bcd_digits[19:16];
            4'd2: digit = bcd_digits[15:12];
            4'd3: digit = bcd_digits[11:8];
            4'd4: digit = bcd_digits[7:4];
            4'd5: digit = bcd_digits[3:0];
            default: digit = 4'd0;
        endcase
        if (!bcd_done) digit = 4'd0;
    end

    always_comb begin
        sel_rs   = 1'b1;
        sel_data = ASCII_SPACE;
        if (init_d) begin
            sel_rs   = 1'b0;
            sel_data = init_cmd(3'(byte_d));
        end else if (byte_d == 6'd0) begin
            sel_rs   = 1'b0;
            sel_data = LCD_LINE1;
        end else if (byte_d <= 6'd16) begin
            case (col_l1)
                4'd0, 4'd1, 4'd2, 4'd3: sel_data = mnemonic_char(fields_q.opcode, col_l1[1:0]);
                4'd5, 4'd8, 4'd11:      sel_data = ASCII_R;
                4'd6:                   sel_data = hex_ascii(fields_q.dest);
                4'd9:                   sel_data = hex_ascii(fields_q.src1);
                4'd12:                  sel_data = hex_ascii(fields_q.src2);
                default:                sel_data = ASCII_SPACE;
            endcase
        end else if (byte_d == 6'd17) begin
            sel_rs   = 1'b0;
            sel_data = LCD_LINE2;
        end else begin
            case (col_l2)
                4'd0:                         sel_data = fields_q.neg ? ASCII_MINUS : ASCII_PLUS;
                4'd1, 4'd2, 4'd3, 4'd4, 4'd5: sel_data = ASCII_ZERO + {4'd0, digit};
                default:                      sel_data = ASCII_SPACE;
            endcase
        end
    end

    // Output logic, evaluated on next state so registered pins line up with it.
    always_comb begin
        ready_d = (state_d == ST_IDLE);
        en_d    = (state_d == ST_PULSE);
        data_d  = data_q;
        rs_d    = rs_q;
        if (state_d == ST_SETUP || state_d == ST_PULSE || state_d == ST_HOLD) begin
            data_d = sel_data;
            rs_d   = sel_rs;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_POWERON;
            cnt_q    <= '0;
            byte_q   <= '0;
            init_q   <= 1'b0;
            fields_q <= '0;
            ready_q  <= 1'b0;
            en_q     <= 1'b0;
            rs_q     <= 1'b0;
            data_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            byte_q   <= byte_d;
            init_q   <= init_d;
            fields_q <= fields_d;
            ready_q  <= ready_d;
            en_q     <= en_d;
            rs_q     <= rs_d;
            data_q   <= data_d;
        end
    end

    assign req.ready = ready_q;
    assign lcd_data  = data_q;
    assign lcd_rs    = rs_q;
    assign lcd_en    = en_q;
    assign lcd_rw    = 1'b0;
endmodule
